// File: rtl/lif_pkg.sv
// lif_pkg: shared definitions for the LIF neuron array and its stimulus path.
//   state_t      - two-state control enum (IDLE / RUN) used by the spike encoder
//   LIF_WIDTH    - default intensity / weight / threshold width
//   LIF_WIN_LOG2 - default log2 of the rate-coding window length
//   cnt_width()  - number of bits needed to hold the range 0..max_val (minimum 1)
package lif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LIF_WIDTH    = 8;
  localparam int LIF_WIN_LOG2 = 8;

  // A zero-width counter is not legal, so small ranges still get one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spike_phase_acc.sv
// spike_phase_acc: phase accumulator with optional refractory suppression.
// Each enabled edge adds value into a WIDTH-bit accumulator; an overflow
// (carry out) is a spike candidate that fires only if no refractory period
// is pending. Dropped candidates are lost, not queued.
//   clk, rst - clock and asynchronous active-high reset
//   clear    - zero the accumulator and refractory counter (window start)
//   enable   - advance the accumulator this edge
//   value    - phase increment (intensity)
//   fire     - combinational: this edge produces an emitted spike
module spike_phase_acc
  import lif_pkg::*;
#(
  parameter int WIDTH   = LIF_WIDTH,
  parameter int REFRACT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             fire
);

  localparam int RW = cnt_width(REFRACT);
  localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);
  localparam logic [RW-1:0] REFR_ONE  = RW'(1);

  logic [WIDTH-1:0] acc_reg;
  logic [RW-1:0]    refr_reg;
  logic [WIDTH:0]   sum;

  // The extra top bit of the sum is the overflow carry.
  assign sum  = {1'b0, acc_reg} + {1'b0, value};
  assign fire = enable && sum[WIDTH] && (refr_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      refr_reg <= '0;
    end else if (clear) begin
      acc_reg  <= '0;
      refr_reg <= '0;
    end else if (enable) begin
      acc_reg <= sum[WIDTH-1:0];
      if (fire) begin
        refr_reg <= REFR_LOAD;
      end else if (refr_reg != '0) begin
        refr_reg <= refr_reg - REFR_ONE;
      end
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: converts an intensity accepted over valid/ready into a
// deterministic rate-coded spike train lasting 2^WIN_LOG2 RUN cycles.
//   clk, rst     - clock and asynchronous active-high reset
//   in_valid     - intensity offered
//   in_ready     - accepting (IDLE and not in reset)
//   in_value     - intensity, latched on the accept edge
//   spike        - registered one-cycle spike, drives a neuron syn input
//   busy         - window in progress
//   done         - one-cycle pulse in the first IDLE cycle after a window
//   spike_count  - spikes emitted in the current / last window
module spike_rate_encoder
  import lif_pkg::*;
#(
  parameter int WIDTH    = LIF_WIDTH,
  parameter int WIN_LOG2 = LIF_WIN_LOG2,
  parameter int REFRACT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_value,
  output logic                spike,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2:0]   spike_count
);

  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1);
  localparam logic [WIN_LOG2:0]   CNT_ONE  = (WIN_LOG2 + 1)'(1);

  state_t                state_reg;
  logic [WIDTH-1:0]      value_reg;
  logic [WIN_LOG2-1:0]   win_reg;
  logic [WIN_LOG2:0]     count_reg;
  logic                  spike_reg;
  logic                  done_reg;

  logic accept;
  logic run_en;
  logic fire;

  // rst is folded into in_ready only; inside the clocked block rst is
  // already known low, so accept does not need it.
  assign accept   = (state_reg == IDLE) && in_valid;
  assign run_en   = (state_reg == RUN);
  assign in_ready = (state_reg == IDLE) && !rst;

  assign spike       = spike_reg;
  assign busy        = run_en;
  assign done        = done_reg;
  assign spike_count = count_reg;

  spike_phase_acc #(
    .WIDTH   (WIDTH),
    .REFRACT (REFRACT)
  ) u_phase_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (run_en),
    .value  (value_reg),
    .fire   (fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      value_reg <= '0;
      win_reg   <= '0;
      count_reg <= '0;
      spike_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          spike_reg <= 1'b0;
          done_reg  <= 1'b0;
          // An accept in the done cycle restarts immediately; the count of
          // the finished window is overwritten on that same edge.
          if (accept) begin
            value_reg <= in_value;
            win_reg   <= '0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          spike_reg <= fire;
          if (fire) begin
            count_reg <= count_reg + CNT_ONE;
          end
          win_reg <= win_reg + WIN_ONE;
          // Last RUN edge still updates normally; done and the final spike
          // appear together in the first IDLE cycle.
          if (win_reg == WIN_LAST) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          spike_reg <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed bench for spike_rate_encoder. Two instances
// (REFRACT=0 and REFRACT=1) share the inputs; rsel picks which one is observed.
module tb_spike_rate_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_value;
  logic       rsel;

  logic       rdy0, spk0, busy0, done0;
  logic [8:0] cnt0;
  logic       rdy1, spk1, busy1, done1;
  logic [8:0] cnt1;

  logic       m_ready, m_spike, m_busy, m_done;
  logic [8:0] m_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_rate_encoder #(.WIDTH(8), .WIN_LOG2(8), .REFRACT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_value(in_value), .spike(spk0), .busy(busy0), .done(done0),
    .spike_count(cnt0)
  );

  spike_rate_encoder #(.WIDTH(8), .WIN_LOG2(8), .REFRACT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_value(in_value), .spike(spk1), .busy(busy1), .done(done1),
    .spike_count(cnt1)
  );

  assign m_ready = rsel ? rdy1  : rdy0;
  assign m_spike = rsel ? spk1  : spk0;
  assign m_busy  = rsel ? busy1 : busy0;
  assign m_done  = rsel ? done1 : done0;
  assign m_count = rsel ? cnt1  : cnt0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer v, then watch the window. Cycle k is sampled 1ns after the k-th
  // edge following the accept edge (cycle 0 = right after accept).
  task automatic run_window(input string tag, input logic [7:0] v,
                            input int exp_n, input int exp_first,
                            input int exp_last, input int exp_adj);
    int  n       = 0;
    int  first   = -1;
    int  last    = -1;
    int  done_at = -1;
    int  adj     = 0;
    bit  prev    = 1'b0;
    @(negedge clk);
    check({tag, ".ready"}, int'(m_ready), 1);
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, int'(m_busy), 1);
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      @(posedge clk); #1;
      if (m_spike) begin
        n++;
        if (first < 0) first = k;
        last = k;
        if (prev) adj = 1;
      end
      prev = m_spike;
      if (m_done) done_at = k;
    end
    check({tag, ".done_cycle"}, done_at, 256);
    check({tag, ".spikes"}, n, exp_n);
    check({tag, ".spike_count"}, int'(m_count), exp_n);
    check({tag, ".first"}, first, exp_first);
    check({tag, ".last"}, last, exp_last);
    check({tag, ".adjacent"}, adj, exp_adj);
    check({tag, ".ready_at_done"}, int'(m_ready), 1);
    @(posedge clk); #1;
    check({tag, ".done_width"}, int'(m_done), 0);
    check({tag, ".idle_spike"}, int'(m_spike), 0);
    check({tag, ".count_hold"}, int'(m_count), exp_n);
    $display("window %s value=%0d spikes=%0d first=%0d last=%0d done=%0d", tag, v, n, first, last, done_at);
  endtask

  typedef struct {
    string      tag;
    logic [7:0] value;
    logic       rsel;
    int         exp_n;
    int         exp_first;
    int         exp_last;
    int         exp_adj;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    int done_at;
    int seen;

    tbl[0] = '{"v128",     8'd128, 1'b0, 128,   2, 256, 0};
    tbl[1] = '{"v1",       8'd1,   1'b0,   1, 256, 256, 0};
    tbl[2] = '{"v0",       8'd0,   1'b0,   0,  -1,  -1, 0};
    tbl[3] = '{"v255_r0",  8'd255, 1'b0, 255,   2, 256, 1};
    tbl[4] = '{"v255_r1",  8'd255, 1'b1, 128,   2, 256, 0};
    tbl[5] = '{"v3",       8'd3,   1'b0,   3,  86, 256, 0};
    tbl[6] = '{"v200",     8'd200, 1'b0, 200,   2, 256, 1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = 8'd0;
    rsel     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", int'(m_ready), 0);
    check("rst.spike", int'(m_spike), 0);
    check("rst.busy", int'(m_busy), 0);
    check("rst.done", int'(m_done), 0);
    check("rst.count", int'(m_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready_after", int'(m_ready), 1);

    // Table-driven windows
    for (int i = 0; i < 7; i++) begin
      rsel = tbl[i].rsel;
      run_window(tbl[i].tag, tbl[i].value, tbl[i].exp_n,
                 tbl[i].exp_first, tbl[i].exp_last, tbl[i].exp_adj);
    end
    rsel = 1'b0;

    // Continuous in_valid, value changed mid-window, back-to-back accept
    @(negedge clk);
    check("hs.ready", int'(m_ready), 1);
    in_value = 8'd128;
    in_valid = 1'b1;
    @(posedge clk); #1;
    n = 0; done_at = -1;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      @(posedge clk); #1;
      if (k == 10) in_value = 8'd3;
      if (m_spike) n++;
      if (m_done) done_at = k;
    end
    check("hs.a_done", done_at, 256);
    check("hs.a_spikes", n, 128);
    check("hs.a_count", int'(m_count), 128);
    check("hs.a_ready", int'(m_ready), 1);
    $display("window hs.a value=128 spikes=%0d done=%0d", n, done_at);
    @(posedge clk); #1;
    check("hs.b_busy", int'(m_busy), 1);
    check("hs.b_done_low", int'(m_done), 0);
    check("hs.b_count_clr", int'(m_count), 0);
    n = 0; done_at = -1;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      @(posedge clk); #1;
      if (k == 20) begin
        in_valid = 1'b0;
        in_value = 8'd50;
      end
      if (m_spike) n++;
      if (m_done) done_at = k;
    end
    check("hs.b_done", done_at, 256);
    check("hs.b_spikes", n, 3);
    check("hs.b_count", int'(m_count), 3);
    $display("window hs.b value=3 spikes=%0d done=%0d", n, done_at);
    @(posedge clk); #1;
    check("hs.end_busy", int'(m_busy), 0);
    check("hs.end_done", int'(m_done), 0);

    // Reset at RUN cycle 100 of a 200-intensity window
    @(negedge clk);
    in_value = 8'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mr.pre_spike", int'(m_spike), 1);
    check("mr.pre_count", int'(m_count), 78);
    check("mr.pre_busy", int'(m_busy), 1);
    rst = 1'b1;
    #1;
    check("mr.spike", int'(m_spike), 0);
    check("mr.busy", int'(m_busy), 0);
    check("mr.count", int'(m_count), 0);
    check("mr.ready", int'(m_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mr.ready_after", int'(m_ready), 1);
    seen = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (m_done || m_busy) seen = 1;
    end
    check("mr.no_done", seen, 0);
    $display("reset mid-run at cycle 100, activity after reset=%0d", seen);
    run_window("mr.fresh", 8'd200, 200, 2, 256, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Transmit-side counterpart of the LIF neuron: converts an 8-bit intensity, accepted over a valid/ready handshake, into a deterministic rate-coded spike train suitable for driving a neuron's single-bit `syn` input. A phase accumulator emits one spike per accumulator overflow over a fixed window of 2^WIN_LOG2 cycles. An optional refractory period suppresses overflows that fall too soon after an emitted spike. The block sits between the stimulus/host interface and the synapse inputs of the neuron array.

## Interface
- WIDTH, 8, intensity and accumulator width
- WIN_LOG2, 8, window length is 2^WIN_LOG2 RUN cycles
- REFRACT, 0, cycles after an emitted spike during which overflows are suppressed (0 = none)

- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  intensity offered
- in_ready  output  1  block can accept; equals (state==IDLE && !rst)
- in_value  input  WIDTH  intensity (spikes per full window when WIN_LOG2==WIDTH, REFRACT==0)
- spike  output  1  registered spike, one cycle wide; connects to a neuron `syn`
- busy  output  1  state==RUN
- done  output  1  one-cycle pulse, registered, first cycle after window end
- spike_count  output  WIN_LOG2+1  spikes emitted in current/last window

## Operation
- Reset values: state IDLE, spike 0, done 0, busy 0, spike_count 0, acc 0, value register 0, window counter 0, refractory counter 0.
- Accept: in IDLE, in_valid && in_ready at an edge latches in_value, clears acc, window counter, refractory counter and spike_count, and moves to RUN. in_value is ignored outside IDLE.
- RUN, each edge:
  - {carry, acc} <= acc + value, using a WIDTH+1-bit sum; acc wraps modulo 2^WIDTH.
  - fire = carry && (refr_cnt==0).
  - spike <= fire.
  - spike_count increments on fire.
  - On fire, refr_cnt <= REFRACT; otherwise refr_cnt decrements toward 0 and saturates at 0.
  - A carry while refr_cnt != 0 is dropped, not deferred.
- The window counter counts RUN edges. The 2^WIN_LOG2-th RUN edge performs a normal update, sets state IDLE and sets done <= 1.
- In IDLE, spike <= 0 and done <= 0 after one cycle; spike_count holds until the next accept.
- spike_count width WIN_LOG2+1 is sufficient because at most one spike occurs per cycle, so it never saturates.
- value==0 produces no spikes and still completes the window with done.

## Timing
- Accept edge -> busy=1 on the following cycle. The first possible spike is visible one cycle after the first RUN edge.
- Window: exactly 2^WIN_LOG2 RUN cycles. done and the final spike (if any) are both visible in the first IDLE cycle.
- in_ready is low for the full window plus 0 extra cycles. Back-to-back windows are possible: an accept in the first IDLE cycle (the done cycle) is legal.
- Simultaneous done and accept: the new accept clears spike_count on that edge. Done still pulses exactly one cycle.
- Asynchronous reset mid-RUN: all state clears immediately and spike drops combinationally with reset; no done is issued. in_ready stays low while rst is high and rises in the first cycle after deassertion.

## Structure
- Shared package lif_pkg:
  - state enum {IDLE, RUN}
  - default WIDTH and WIN_LOG2 constants, shared with the neuron's weight/threshold width
- One sub-module, spike_phase_acc: holds acc and the refractory counter, takes value, enable and clear, and produces fire.
- The top level holds the FSM, window counter, handshake, spike_count and output registers.

## Test plan
- Defaults, in_value=128: exactly 128 spikes, one every other cycle, the first in the 2nd RUN cycle. done asserts 256 cycles after accept, with spike_count=128.
- in_value=1: a single spike, coincident with done in the first IDLE cycle; spike_count=1. Separately, in_value=0: no spikes, done still at 256, spike_count=0.
- in_value=255 with REFRACT=0 gives 255 spikes. in_value=255 with REFRACT=1 gives 128 spikes, never two in consecutive cycles.
- Handshake: hold in_valid high continuously while changing in_value during RUN. Each window uses the value latched at its accept edge, and a second accept occurs in the done cycle with no idle gap.
- Assert rst for 1 cycle at RUN cycle 100 of a 200-intensity window: spike, busy and spike_count go to 0 immediately and no done is issued. in_ready returns the cycle after rst falls, and a fresh window of 200 completes with spike_count=200.
